// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the instruction memory.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 512;
  localparam int unsigned IMEM_ADDR_W = 9;
  localparam int unsigned IMEM_HALF_W = 16;
  localparam int unsigned IMEM_WORD_W = 2 * IMEM_HALF_W;
  localparam int unsigned IMEM_BYTES  = IMEM_WORD_W / 8;
  localparam int unsigned IMEM_IDX_W  = $clog2(IMEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             byte_data,
  output logic [IMEM_WORD_W-1:0] word_c,
  output logic                   word_full_c
);

  localparam int unsigned LOW_W = IMEM_WORD_W - 8;

  logic [IMEM_IDX_W-1:0] byte_idx;
  logic [LOW_W-1:0]      low_bytes;

  // The 4th byte is presented combinationally so the word is complete on its accept edge.
  assign word_c      = {byte_data, low_bytes};
  assign word_full_c = accept && (byte_idx == IMEM_IDX_W'(IMEM_BYTES - 1));

  // Byte index counter and shift register holding the first three bytes of a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= '0;
      low_bytes <= '0;
    end else if (clear) begin
      byte_idx  <= '0;
    end else if (accept) begin
      byte_idx  <= byte_idx + IMEM_IDX_W'(1);
      low_bytes <= {byte_data, low_bytes[LOW_W-1:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image byte stream into the 512x32 instruction store.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W:0]        word_count,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_cen,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [IMEM_HALF_W-1:0] mem_d_low,
  output logic [IMEM_HALF_W-1:0] mem_d_high,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [IMEM_WORD_W-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("imem_loader: ADDR_W must equal clog2(DEPTH)");
  end

  loader_state_e          state;
  logic [CNT_W-1:0]       count;
  logic [ADDR_W-1:0]      word_idx;
  logic [IMEM_WORD_W-1:0] word_c;
  logic                   word_full_c;
  logic                   accept_c;
  logic                   count_ok_c;
  logic                   last_word_c;

  assign accept_c    = byte_valid && byte_ready;
  assign count_ok_c  = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
  assign last_word_c = (CNT_W'(word_idx) == (count - CNT_W'(1)));

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (state == IDLE),
    .accept      (accept_c),
    .byte_data   (byte_data),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  // Loader FSM with address counter, checksum and registered memory strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      mem_cen    <= 1'b1;
      mem_wen    <= 1'b1;
      mem_addr   <= '0;
      mem_d_low  <= '0;
      mem_d_high <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done <= 1'b0;
            if (count_ok_c) begin
              count      <= word_count;
              error      <= 1'b0;
              checksum   <= '0;
              word_idx   <= '0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end else begin
              error <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (word_full_c) begin
            byte_ready <= 1'b0;
            mem_cen    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= word_idx;
            mem_d_low  <= word_c[IMEM_HALF_W-1:0];
            mem_d_high <= word_c[IMEM_WORD_W-1:IMEM_HALF_W];
            state      <= WRITE;
          end
        end
        WRITE: begin
          mem_cen  <= 1'b1;
          mem_wen  <= 1'b1;
          checksum <= checksum + {mem_d_high, mem_d_low};
          if (last_word_c) begin
            state <= DONE;
          end else begin
            word_idx   <= word_idx + ADDR_W'(1);
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: loads a program image into the 512x32 instruction store (two 16-bit halves, low and high) before the core runs.
- Accepts a byte stream over a valid/ready handshake and packs four bytes into one 32-bit word, little-endian.
- Writes each word in a single cycle to both halves at the same word address, using active-low chip enable and active-low write enable.
- Reports busy, done, error and a running 32-bit checksum. The memory side gets its clock from clk, the same clock the instruction fetch path uses.

Parameters:
- DEPTH, 512, number of 32-bit words in the instruction store.
- ADDR_W, 9, word address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  ADDR_W+1  number of words to load; captured on an accepted start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  program byte, least-significant byte of each word first.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_cen  output  1  active-low chip enable to both halves.
- mem_wen  output  1  active-low write enable to both halves.
- mem_addr  output  ADDR_W  word address.
- mem_d_low  output  16  write data to the low half, word bits [15:0].
- mem_d_high  output  16  write data to the high half, word bits [31:16].
- busy  output  1  load in progress.
- done  output  1  sticky: last load completed.
- error  output  1  sticky: last start was rejected.
- checksum  output  32  mod-2^32 sum of all words written in the current or last load.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: byte_ready=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_d_low=0, mem_d_high=0, busy=0, done=0, error=0, checksum=0, state=IDLE.
- IDLE:
  - start=1 with 1<=word_count<=DEPTH: latch word_count, clear done, error, checksum and the address counter, go to COLLECT.
  - start=1 with word_count=0 or word_count>DEPTH: set error=1, clear done, stay in IDLE.
- COLLECT:
  - byte_ready=1 and busy=1.
  - A byte is accepted on a cycle where byte_valid && byte_ready.
  - The byte index (0..3) selects word bits [8i+7:8i]; index 0 goes to bits [7:0].
  - On the 4th accepted byte, go to WRITE. byte_valid low stalls with no side effect.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_cen=0, mem_wen=0.
  - mem_addr = current word index; mem_d_high/mem_d_low = packed word.
  - checksum += word.
  - If index == word_count-1, go to DONE; otherwise index++, byte index = 0, go to COLLECT.
- DONE (one cycle): set done=1, clear busy, go to IDLE.
- Latency: 4th byte of a word accepted at edge N; write strobe during cycle N+1; after the last word, done=1 from edge N+2.
- Throughput: at most 1 word per 5 cycles.
- Outside WRITE: mem_cen=1 and mem_wen=1. mem_addr and mem_d_* hold their last value.
- start while busy: ignored; no change to error.
- A partially collected word at reset is discarded; no memory write occurs.
- Address wrap: cannot occur, because word_count is bounded by DEPTH and the index stops at word_count-1.
- Flag lifetime: done and error stay set until the next accepted or rejected start, or reset.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH=512, IMEM_ADDR_W=9, IMEM_HALF_W=16.
  - Loader state enum {IDLE, COLLECT, WRITE, DONE}.
  - The same constants are used by the fetch-side memory wrapper.
- One natural sub-module: imem_word_packer.
  - Contains the byte index counter, the 32-bit shift/pack register and a word_full pulse.
  - Has a clear input driven from the FSM.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Basic load: start with word_count=2, bytes 78 56 34 12 EF BE AD DE -> writes addr0=0x12345678 (d_high=0x1234, d_low=0x5678) and addr1=0xDEADBEEF, each write one cycle with cen=wen=0; done=1, checksum=0xF0E21567.
- Bad count: start with word_count=0 -> error=1, busy=0, no memory strobe. Then start with word_count=513 -> error=1 again. Then a valid start -> error cleared.
- Backpressure: byte_valid toggled 1-0-0-1-... across word_count=1 -> exactly 4 bytes accepted, one write to addr0. byte_ready=0 during the WRITE cycle even with byte_valid=1.
- Full depth: word_count=512 with word i = i -> last write at addr 0x1FF = 0x000001FF; checksum=0x0001FF00; no write to addr 0 after the start.
- Reset mid-word: assert rst after 2 bytes of word 3 -> all outputs at reset values immediately. A new load of 1 word then writes addr0 with no residue of the old bytes.
- start while busy: start pulsed during COLLECT with word_count=5 -> ignored; the load finishes with the originally latched count.
